display_scanner: RTL and testbench
==================================

# display_scanner

Time-multiplexed digit scanner that sits directly upstream of the 7-segment decoder. It latches a multi-digit hexadecimal value and cycles through its nibbles at a prescaled refresh rate. For each dwell slot it presents one nibble on `number` together with a one-hot digit enable and a blank flag. New values are double-buffered, so a displayed frame never mixes old and new digits.

## Interface
Parameters:
- `DIGITS`, default 4: number of multiplexed digits; must be ≥2.
- `PRESCALE`, default 50000: clock cycles per digit dwell; must be ≥1.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: reset. Synchronous, active-high.
- `value`, in, 4*DIGITS: value to display. Nibble i drives digit i; digit 0 is least significant.
- `load`, in, 1: one-cycle strobe that captures `value` into the pending buffer.
- `enable`, in, 1: 1 = scan and drive digits. 0 = digits dark, scan frozen.
- `blank_lz`, in, 1: 1 = suppress leading zeros.
- `number`, out, 4: nibble for the current digit. Feeds the decoder input.
- `digit_en`, out, DIGITS: one-hot active-high digit select. All zero when dark.
- `blank`, out, 1: 1 = current digit must be shown dark (the decoder output is ignored).
- `frame_done`, out, 1: one-cycle pulse when the last digit's dwell ends.

## Operation
- State registers:
  - `pre`: prescaler, 0..PRESCALE-1.
  - `idx`: digit index, 0..DIGITS-1.
  - `active`: displayed value, 4*DIGITS bits.
  - `pending`: buffered value, 4*DIGITS bits.
  - `pend_v`: pending-valid flag.
- Tick: `tick = enable && pre == PRESCALE-1`.
- Prescaler:
  - When `enable`=1: `pre` increments each cycle and wraps to 0 on tick.
  - When `enable`=0: `pre` and `idx` hold.
- Index: on tick, `idx` increments. At DIGITS-1 it wraps to 0; this is the frame boundary.
- Load and buffering:
  - `load`: `pending <= value`, `pend_v <= 1`. A later load before the frame boundary overwrites `pending`; the last load wins.
  - Frame boundary, case 1: `load`=1 in the same cycle. `active <= value`, `pend_v <= 0`.
  - Frame boundary, case 2: `load`=0 and `pend_v`=1. `active <= pending`, `pend_v <= 0`.
  - Frame boundary, case 3: `load`=0 and `pend_v`=0. `active` holds.
  - `active` changes only at a frame boundary. It never changes mid-frame, and it does not update while `enable`=0.
- Leading-zero suppression:
  - Digit i (i ≥ 1) is a leading zero when `active` nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
- Outputs (registered every cycle from current state):
  - `number <= active[4*idx +: 4]`.
  - `digit_en <= enable ? (1 << idx) : 0`.
  - `blank <= !enable || (blank_lz && leading_zero(idx))`.
  - `frame_done <= tick && idx == DIGITS-1`.
- Reset:
  - State: `pre`=0, `idx`=0, `active`=0, `pending`=0, `pend_v`=0.
  - Outputs: `number`=0, `digit_en`=0, `blank`=1, `frame_done`=0.
  - Reset overrides a simultaneous `load`. Reset mid-frame discards the pending value.

## Timing
- Outputs lag state by exactly one cycle.
  - A tick at edge N changes `idx`; `number` and `digit_en` reflect the new digit after edge N+1.
- Dwell and frame length:
  - Each digit is driven for PRESCALE consecutive cycles while enabled.
  - One frame is DIGITS*PRESCALE cycles.
  - With PRESCALE=1, `idx` advances every cycle.
- `frame_done` is high for exactly 1 cycle per frame. It goes high on the same edge that first presents digit 0 of the next frame, which shows the new `active` value one cycle later.
- Latency from `load` to display: at most one full frame + 2 cycles.
- `enable` 1→0: `digit_en`=0 and `blank`=1 one cycle later. 0→1: scanning resumes from the held `pre`/`idx`.
- `blank_lz` and `enable` are sampled every cycle; no synchronisation is applied.

## Test plan
All scenarios use DIGITS=4, PRESCALE=4.
1. Reset, then `load` `value`=16'h1A3F with `enable`=1. Required response:
   - Initial frame shows 0.
   - Second frame shows `number`=F,3,A,1 with `digit_en`=0001,0010,0100,1000, 4 cycles each.
   - `frame_done` pulses every 16 cycles.
2. `load` 16'h0050 with `blank_lz`=1. Required response:
   - Digits 0 and 1 show 0 and 5 with `blank`=0.
   - Digits 2 and 3 have `blank`=1.
   - Repeat with 16'h0000: only digit 0 is unblanked.
3. `load` 16'h1111 mid-frame, then 16'h2222 two cycles later. Required response: the current frame is unchanged; the next frame shows all 2s; 1111 is never displayed.
4. `load` 16'hBEEF in the same cycle as the tick at `idx`=3, while `pending`=16'h1234 is valid. Required response: the next frame shows BEEF, never 1234; `pend_v`=0 afterwards.
5. Deassert `enable` for 10 cycles mid-dwell. Required response:
   - `digit_en`=0 and `blank`=1 after 1 cycle.
   - `idx` and `pre` hold.
   - On re-enable, the same digit finishes its remaining dwell cycles.
6. Assert `rst` mid-frame with `pend_v`=1. Required response: all outputs take their reset values on the next cycle, and the pending value is never displayed.

Source files
------------

// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed hex digit scanner feeding a 7-segment decoder.
// It holds a double-buffered value and walks its nibbles at a prescaled dwell rate.
// It drives one nibble, a one-hot digit select and a blank flag per dwell slot.

// Per-digit slice: select decode, nibble gating and leading-zero chain link.
module display_scanner_lane #(
  parameter int LANE = 0,
  parameter int IW   = 2
) (
  input  logic [3:0]    nib_i,      // this digit's nibble of the displayed value
  input  logic [IW-1:0] idx_i,      // current scan index
  input  logic          lz_above_i, // every more-significant digit is zero
  output logic          sel_o,      // this digit is the one being scanned
  output logic          lz_o,       // this digit and all above it are zero
  output logic [3:0]    nib_sel_o   // nibble when selected, else zero (OR-mux input)
);
  assign sel_o     = (idx_i == IW'(LANE));
  assign lz_o      = lz_above_i && (nib_i == 4'h0);
  assign nib_sel_o = sel_o ? nib_i : 4'h0;
endmodule

module display_scanner #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  enable,
  input  logic                  blank_lz,
  output logic [3:0]            number,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  blank,
  output logic                  frame_done
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam int VW = 4 * DIGITS;
  localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  // Digit 0 always stays lit so a zero value still shows "0".
  localparam logic [DIGITS-1:0] LZ_MASK  = ~(DIGITS'(1));

  // Scan and buffer state
  logic [PW-1:0] pre_q, pre_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [VW-1:0] active_q, active_d;
  logic [VW-1:0] pend_q, pend_d;
  logic          pend_v_q, pend_v_d;

  // Registered outputs
  logic [3:0]        number_q, number_d;
  logic [DIGITS-1:0] digit_en_q, digit_en_d;
  logic              blank_q, blank_d;
  logic              frame_done_q, frame_done_d;

  // Lane fabric
  logic [DIGITS-1:0]      sel;
  logic [DIGITS:0]        lz_chain;
  logic [DIGITS-1:0][3:0] nib_sel;
  logic [3:0]             nib_mux;
  logic                   cur_lz;
  logic                   tick;
  logic                   frame_end;

  // The chain starts "all zero" above the most significant digit.
  assign lz_chain[DIGITS] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_lane
      display_scanner_lane #(.LANE(g), .IW(IW)) u_lane (
        .nib_i      (active_q[4*g +: 4]),
        .idx_i      (idx_q),
        .lz_above_i (lz_chain[g+1]),
        .sel_o      (sel[g]),
        .lz_o       (lz_chain[g]),
        .nib_sel_o  (nib_sel[g])
      );
    end
  endgenerate

  // Collapse the per-lane gated nibbles into the scanned digit's nibble.
  always_comb begin
    nib_mux = '0;
    for (int i = 0; i < DIGITS; i++) nib_mux = nib_mux | nib_sel[i];
  end

  assign cur_lz    = |(sel & lz_chain[DIGITS-1:0] & LZ_MASK);
  assign tick      = enable && (pre_q == PRE_LAST);
  assign frame_end = tick && (idx_q == IDX_LAST);

  // Next state: prescaler, scan index and double-buffered value.
  always_comb begin
    pre_d    = pre_q;
    idx_d    = idx_q;
    active_d = active_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;

    if (enable) pre_d = tick ? '0 : pre_q + PW'(1);
    if (tick)   idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    if (load) begin
      pend_d   = value;
      pend_v_d = 1'b1;
    end

    // A load on the boundary cycle bypasses the buffer so the newest value wins.
    if (frame_end) begin
      if (load) begin
        active_d = value;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        active_d = pend_q;
        pend_v_d = 1'b0;
      end
    end
  end

  // Next outputs, derived from the current (pre-edge) state.
  always_comb begin
    number_d     = nib_mux;
    digit_en_d   = enable ? sel : '0;
    blank_d      = !enable || (blank_lz && cur_lz);
    frame_done_d = frame_end;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      number_q     <= 4'h0;
      digit_en_q   <= '0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      number_q     <= number_d;
      digit_en_q   <= digit_en_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign number     = number_q;
  assign digit_en   = digit_en_q;
  assign blank      = blank_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with DIGITS=4, PRESCALE=4 (16-cycle frames).
module tb_display_scanner;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0;
  logic        load = 1'b0;
  logic        enable = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  number;
  logic [3:0]  digit_en;
  logic        blank;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  display_scanner #(.DIGITS(4), .PRESCALE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .number     (number),
    .digit_en   (digit_en),
    .blank      (blank),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] ev);
    n_tests++;
    if (got !== ev) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, ev);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".num"},  32'(number),     32'h0);
    chk({nm, ".den"},  32'(digit_en),   32'h0);
    chk({nm, ".blk"},  32'(blank),      32'h1);
    chk({nm, ".fd"},   32'(frame_done), 32'h0);
  endtask

  // One digit slot: expected nibble of ev at digit d.
  task automatic chk_slot(input string nm, input logic [15:0] ev, input int d,
                          input logic bl, input logic fd);
    chk({nm, ".num"}, 32'(number),     32'(ev[4*d +: 4]));
    chk({nm, ".den"}, 32'(digit_en),   32'(4'b0001 << d));
    chk({nm, ".blk"}, 32'(blank),      32'(bl));
    chk({nm, ".fd"},  32'(frame_done), 32'(fd));
  endtask

  // Walk one full frame starting right after a frame boundary (or reset).
  // Load strobes may be placed at step la (value va) and lb (value vb).
  task automatic run_frame(input string nm, input logic [15:0] ev, input logic [3:0] blk,
                           input int la, input logic [15:0] va,
                           input int lb, input logic [15:0] vb);
    for (int j = 0; j < 16; j++) begin
      int d;
      load  = (j == la) || (j == lb);
      value = (j == lb) ? vb : va;
      step();
      d = j / 4;
      chk_slot($sformatf("%s[%0d]", nm, j), ev, d, blk[d], j == 15);
    end
    load = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk_reset("reset");

    // 1: first frame shows the reset value, second shows 1A3F
    rst    = 1'b0;
    enable = 1'b1;
    run_frame("f0_zero", 16'h0000, 4'b0000, 0, 16'h1A3F, -1, 16'h0);
    run_frame("f1_1A3F", 16'h1A3F, 4'b0000, -1, 16'h0, -1, 16'h0);

    // 2: leading-zero blanking
    blank_lz = 1'b1;
    run_frame("f2_1A3F", 16'h1A3F, 4'b0000, 0, 16'h0050, -1, 16'h0);
    run_frame("f3_0050", 16'h0050, 4'b1100, 0, 16'h0000, -1, 16'h0);

    // 3: two loads mid-frame, last one wins
    run_frame("f4_0000", 16'h0000, 4'b1110, 5, 16'h1111, 7, 16'h2222);

    // 4: pending 1234, then BEEF on the boundary tick
    run_frame("f5_2222", 16'h2222, 4'b0000, 3, 16'h1234, 15, 16'hBEEF);
    run_frame("f6_BEEF", 16'hBEEF, 4'b0000, 0, 16'h4321, -1, 16'h0);

    // 5: disable mid-dwell of digit 1 for 10 cycles
    for (int j = 0; j < 5; j++) begin
      step();
      chk_slot($sformatf("f7_pre[%0d]", j), 16'h4321, j / 4, 1'b0, 1'b0);
    end
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("dark[%0d].den", k), 32'(digit_en),   32'h0);
      chk($sformatf("dark[%0d].blk", k), 32'(blank),      32'h1);
      chk($sformatf("dark[%0d].fd", k),  32'(frame_done), 32'h0);
      chk($sformatf("dark[%0d].num", k), 32'(number),     32'h2);
    end
    enable = 1'b1;
    for (int k = 0; k < 11; k++) begin
      int d;
      d = (k < 3) ? 1 : ((k < 7) ? 2 : 3);
      step();
      chk_slot($sformatf("resume[%0d]", k), 16'h4321, d, 1'b0, k == 10);
    end

    // 6: reset mid-frame with a pending value (and a load during reset)
    load  = 1'b1;
    value = 16'h7777;
    step();
    load = 1'b0;
    step();
    rst   = 1'b1;
    load  = 1'b1;
    value = 16'h9999;
    step();
    chk_reset("midreset");
    rst  = 1'b0;
    load = 1'b0;
    run_frame("r0_zero", 16'h0000, 4'b1110, -1, 16'h0, -1, 16'h0);
    run_frame("r1_zero", 16'h0000, 4'b1110, -1, 16'h0, -1, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
